// File: rtl/fp16_pkg.sv
`default_nettype none
// =============================================================================
// Module : fp16_pkg
// Brief  : FP16 field layout, special encodings and multiplier pipeline depth.
// Rev    : 1.0  initial release
// =============================================================================
package fp16_pkg;

   localparam int         FP16_W       = 16;
   localparam int         EXP_W        = 5;
   localparam int         FRAC_W       = 10;
   localparam logic [4:0] EXP_MAX      = 5'h1f;
   localparam logic [15:0] FP16_QNAN    = 16'h7e00;
   localparam logic [15:0] FP16_POS_INF = 16'h7c00;
   localparam logic [15:0] FP16_ONE     = 16'h3c00;
   localparam int         FP16_MUL_LAT = 6;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp16_t;

endpackage
`default_nettype wire

// File: rtl/fp16_result_fifo.sv
`default_nettype none
// =============================================================================
// Module : fp16_result_fifo
// Brief  : Synchronous FIFO with show-ahead head and extra-MSB full/empty.
// Rev    : 1.0  initial release
// =============================================================================
module fp16_result_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wr_en,
   input  logic [W-1:0]             i_wr_data,
   input  logic                     i_rd_en,
   output logic [W-1:0]             o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int c_aw = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [c_aw:0] r_wr_ptr;
   logic [c_aw:0] r_rd_ptr;
   logic          w_do_wr;
   logic          w_do_rd;

   assign w_do_wr = i_wr_en && !o_full;
   assign w_do_rd = i_rd_en && !o_empty;

   // Storage needs no reset: an entry is only ever read after being written.
   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                      (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

endmodule
`default_nettype wire

// File: rtl/fp16_mul_issue_ctrl.sv
`default_nettype none
// =============================================================================
// Module : fp16_mul_issue_ctrl
// Brief  : Credit-based issue/collect wrapper around a fixed-latency FP16 mult.
// Rev    : 1.0  initial release
// =============================================================================
module fp16_mul_issue_ctrl
   import fp16_pkg::*;
#(
   parameter int MUL_LAT    = FP16_MUL_LAT,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [FP16_W-1:0] s_a,
   input  logic [FP16_W-1:0] s_b,
   output logic [FP16_W-1:0] mul_a,
   output logic [FP16_W-1:0] mul_b,
   input  logic [FP16_W-1:0] mul_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [FP16_W-1:0] m_data,
   output logic              m_nan,
   output logic              m_inf,
   output logic              m_zero,
   output logic              busy
);

   logic [MUL_LAT:0] r_vld_sr;
   logic [CNT_W-1:0] r_inflight;
   logic [CNT_W-1:0] w_fifo_count;
   logic [CNT_W:0]   w_credit_sum;
   logic             w_fifo_empty;
   logic             w_fifo_full;
   logic             w_accept;
   logic             w_wr;
   logic             w_pop;
   fp16_t            w_head;

   // Every accepted pair reserves a FIFO slot up front, so the multiplier
   // output can never be dropped even with m_ready held low.
   assign w_credit_sum = {1'b0, r_inflight} + {1'b0, w_fifo_count};
   assign s_ready      = (w_credit_sum < (CNT_W+1)'(FIFO_DEPTH));

   assign w_accept = s_valid && s_ready;
   assign w_wr     = r_vld_sr[MUL_LAT];
   assign w_pop    = m_valid && m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_a      <= '0;
         mul_b      <= '0;
         r_vld_sr   <= '0;
         r_inflight <= '0;
      end else begin
         r_vld_sr <= {r_vld_sr[MUL_LAT-1:0], w_accept};
         if (w_accept) begin
            mul_a <= s_a;
            mul_b <= s_b;
         end
         if (w_accept && !w_wr) begin
            r_inflight <= r_inflight + CNT_W'(1);
         end else if (!w_accept && w_wr) begin
            r_inflight <= r_inflight - CNT_W'(1);
         end
      end
   end

   fp16_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FP16_W)
   ) u_result_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr),
      .i_wr_data (mul_out),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_count   (w_fifo_count),
      .o_empty   (w_fifo_empty),
      .o_full    (w_fifo_full)
   );

   assign m_valid = !w_fifo_empty;
   assign m_data  = w_head;
   assign m_nan   = (w_head.exp == EXP_MAX) && (w_head.frac != '0);
   assign m_inf   = (w_head.exp == EXP_MAX) && (w_head.frac == '0);
   assign m_zero  = (w_head.exp == '0) && (w_head.frac == '0);
   assign busy    = (r_inflight != '0) || !w_fifo_empty;

   a_no_full_write: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_wr && w_fifo_full));

endmodule
`default_nettype wire

// File: tb/tb_fp16_mul_issue_ctrl.sv
`default_nettype none
// =============================================================================
// Module : tb_fp16_mul_issue_ctrl
// Brief  : Directed vector bench with a 6-stage behavioural FP16 multiplier.
// Rev    : 1.0  initial release
// =============================================================================
module tb_fp16_mul_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_a;
   logic [15:0] s_b;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic [15:0] mul_out;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        m_nan;
   logic        m_inf;
   logic        m_zero;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp16_mul_issue_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_a     (s_a),
      .s_b     (s_b),
      .mul_a   (mul_a),
      .mul_b   (mul_b),
      .mul_out (mul_out),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_nan   (m_nan),
      .m_inf   (m_inf),
      .m_zero  (m_zero),
      .busy    (busy)
   );

   // Truncating FP16 multiply; subnormals flush to zero, NaN is canonical.
   function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
      logic        s;
      logic [4:0]  ea, eb;
      logic [9:0]  fa, fb, fr;
      logic [21:0] p;
      int          e;
      s  = a[15] ^ b[15];
      ea = a[14:10]; eb = b[14:10];
      fa = a[9:0];   fb = b[9:0];
      if ((ea == 5'h1f && fa != 0) || (eb == 5'h1f && fb != 0)) return 16'h7e00;
      if (ea == 5'h1f || eb == 5'h1f) begin
         if ((ea == 0 && fa == 0) || (eb == 0 && fb == 0)) return 16'h7e00;
         return {s, 15'h7c00};
      end
      if (ea == 0 || eb == 0) return {s, 15'h0000};
      p = 22'({1'b1, fa}) * 22'({1'b1, fb});
      e = int'(ea) + int'(eb) - 15;
      if (p[21]) begin
         e  = e + 1;
         fr = p[20:11];
      end else begin
         fr = p[19:10];
      end
      if (e >= 31) return {s, 15'h7c00};
      if (e <= 0)  return {s, 15'h0000};
      return {s, 5'(e), fr};
   endfunction

   logic [15:0] pipe [6];
   always @(posedge clk) begin
      pipe[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
   end
   assign mul_out = pipe[5];

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_data;
      logic        exp_nan;
      logic        exp_inf;
      logic        exp_zero;
   } vec_t;

   vec_t        vecs [9];
   logic [15:0] ktab [20];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!m_valid && n < 20) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, acc, r, last_c, low_cycles, vcount;
      bit seen_ready, dropped, rerose;

      vecs[0] = '{16'h3c00, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h4200, 16'h4200, 16'h4880, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{16'hc000, 16'h4000, 16'hc400, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{16'h3800, 16'h3800, 16'h3400, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{16'h7c00, 16'h0000, 16'h7e00, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{16'h7c00, 16'h3c00, 16'h7c00, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'h3c00, 16'h8000, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{16'h7e01, 16'h3c00, 16'h7e00, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{16'hfc00, 16'h3c00, 16'hfc00, 1'b0, 1'b1, 1'b0};
      ktab = '{16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
               16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900,
               16'h4980, 16'h4a00, 16'h4a80, 16'h4b00, 16'h4b80,
               16'h4c00, 16'h4c40, 16'h4c80, 16'h4cc0, 16'h4d00};

      rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_busy",    32'(busy),    0);
      check("rst_s_ready", 32'(s_ready), 1);
      check("rst_mul_a",   32'(mul_a),   0);
      check("rst_mul_b",   32'(mul_b),   0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Single-op vectors: latency, data and class flags.
      m_ready = 1'b1;
      for (int v = 0; v < 9; v++) begin
         check($sformatf("v%0d_s_ready", v), 32'(s_ready), 1);
         s_valid = 1'b1; s_a = vecs[v].a; s_b = vecs[v].b;
         tick();
         s_valid = 1'b0;
         wait_valid(n);
         check($sformatf("v%0d_latency", v), 32'(n), 7);
         check($sformatf("v%0d_data", v), 32'(m_data), 32'(vecs[v].exp_data));
         check($sformatf("v%0d_nan", v),  32'(m_nan),  32'(vecs[v].exp_nan));
         check($sformatf("v%0d_inf", v),  32'(m_inf),  32'(vecs[v].exp_inf));
         check($sformatf("v%0d_zero", v), 32'(m_zero), 32'(vecs[v].exp_zero));
         tick();
         check($sformatf("v%0d_busy_after_pop", v), 32'(busy), 0);
         check($sformatf("v%0d_valid_after_pop", v), 32'(m_valid), 0);
      end

      // 20 back-to-back pairs with m_ready held high.
      r = 0; last_c = -1; low_cycles = 0;
      for (int c = 0; c < 40; c++) begin
         if (m_valid) begin
            if (r < 20) check($sformatf("b2b_data%0d", r), 32'(m_data), 32'(ktab[r]));
            if (r > 0) check($sformatf("b2b_gap%0d", r), 32'(c - last_c), 1);
            last_c = c;
            r++;
         end
         if (c < 20) begin
            s_valid = 1'b1; s_a = ktab[c]; s_b = 16'h3c00;
            if (!s_ready) low_cycles++;
         end else begin
            s_valid = 1'b0;
         end
         tick();
      end
      check("b2b_ready_low_cycles", 32'(low_cycles), 0);
      check("b2b_result_count", 32'(r), 20);

      // Fill with m_ready low: credits run out after exactly 16 accepts.
      m_ready = 1'b0; acc = 0; dropped = 1'b0; rerose = 1'b0;
      for (int c = 0; c < 30; c++) begin
         s_valid = 1'b1; s_a = ktab[acc < 20 ? acc : 0]; s_b = 16'h3c00;
         seen_ready = s_ready;
         if (!s_ready) dropped = 1'b1;
         else if (dropped) rerose = 1'b1;
         tick();
         if (seen_ready) acc++;
      end
      s_valid = 1'b0;
      check("full_accepts", 32'(acc), 16);
      check("full_ready_rerose", 32'(rerose), 0);
      check("full_s_ready", 32'(s_ready), 0);
      m_ready = 1'b1;
      check("drain_first_valid", 32'(m_valid), 1);
      check("drain_data0", 32'(m_data), 32'(ktab[0]));
      tick();
      check("drain_ready_after_first_pop", 32'(s_ready), 1);
      r = 1; n = 0;
      while (r < 16 && n < 30) begin
         if (m_valid) begin
            check($sformatf("drain_data%0d", r), 32'(m_data), 32'(ktab[r]));
            r++;
         end
         tick();
         n++;
      end
      check("drain_count", 32'(r), 16);
      check("drain_empty", 32'(m_valid), 0);

      // Reset with 3 results queued and 5 operations in flight.
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_a = ktab[i]; s_b = 16'h3c00;
         tick();
      end
      s_valid = 1'b0;
      repeat (8) tick();
      check("pre_rst_valid", 32'(m_valid), 1);
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_a = ktab[i+3]; s_b = 16'h3c00;
         tick();
      end
      s_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      check("midrst_m_valid", 32'(m_valid), 0);
      check("midrst_busy",    32'(busy),    0);
      check("midrst_s_ready", 32'(s_ready), 1);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
      m_ready = 1'b1; vcount = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_valid || busy) vcount++;
         tick();
      end
      check("post_rst_stale_results", 32'(vcount), 0);

      // Pop of the only entry coincides with the next write.
      m_ready = 1'b0;
      s_valid = 1'b1; s_a = 16'h4000; s_b = 16'h3c00;
      tick();
      s_a = 16'h4200;
      tick();
      s_valid = 1'b0;
      wait_valid(n);
      check("wp_latency", 32'(n), 6);
      check("wp_head0", 32'(m_data), 32'h4000);
      m_ready = 1'b1;
      tick();
      check("wp_valid1", 32'(m_valid), 1);
      check("wp_head1", 32'(m_data), 32'h4200);
      tick();
      check("wp_no_dup", 32'(m_valid), 0);
      check("wp_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
